// File: rtl/alu_seq_if.sv
//------------------------------------------------------------------------------
// alu_seq_if : request/response bundle between an ALU_SEQ master and the ALU.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [3:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             ovf;

    modport master (
        output start, mode, a, b,
        input  busy, done, result, zero, carry, ovf
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, zero, carry, ovf
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
//------------------------------------------------------------------------------
// alu_seq : multi-cycle ALU; single-cycle logic/arith, serial shifts and an
//           optional shift-add multiplier enabled by macro ALU_SEQ_MUL_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic  clk,
    input  wire logic  reset,
    alu_seq_if.slave   bus
);

    localparam logic [3:0] c_add = 4'd0;
    localparam logic [3:0] c_sub = 4'd1;
    localparam logic [3:0] c_and = 4'd2;
    localparam logic [3:0] c_or  = 4'd3;
    localparam logic [3:0] c_xor = 4'd4;
    localparam logic [3:0] c_slt = 4'd5;
    localparam logic [3:0] c_sll = 4'd6;
    localparam logic [3:0] c_srl = 4'd7;
    localparam logic [3:0] c_sra = 4'd8;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] c_mul = 4'd9;
    localparam int         c_cw  = $clog2(WIDTH + 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [3:0]       r_mode;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [c_cw-1:0]    r_mcnt;
    logic [2*WIDTH-1:0] w_acc_nxt;
`endif

    logic             w_sub_like;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH:0]   w_sum_full;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_ovf;
    logic             w_is_addsub;
    logic             w_is_shift;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_load;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_carry_nxt;
    logic             w_ovf_nxt;

    // Shared adder: SUB and SLT use a + ~b + 1
    assign w_sub_like  = (bus.mode == c_sub) || (bus.mode == c_slt);
    assign w_bop       = w_sub_like ? ~bus.b : bus.b;
    assign w_sum_full  = {1'b0, bus.a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_sub_like};
    assign w_sum       = w_sum_full[WIDTH-1:0];
    assign w_add_ovf   = (bus.a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
    assign w_is_addsub = (bus.mode == c_add) || (bus.mode == c_sub);
    assign w_is_shift  = (bus.mode == c_sll) || (bus.mode == c_srl) || (bus.mode == c_sra);
    assign w_shamt     = bus.b[SHW-1:0];

    always_comb begin
        w_alu_res = '0;
        case (bus.mode)
            c_add, c_sub: w_alu_res = w_sum;
            c_and:        w_alu_res = bus.a & bus.b;
            c_or:         w_alu_res = bus.a | bus.b;
            c_xor:        w_alu_res = bus.a ^ bus.b;
            c_slt:        w_alu_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
            default:      w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_a;
        case (r_mode)
            c_sll:   w_shift_nxt = {r_a[WIDTH-2:0], 1'b0};
            c_srl:   w_shift_nxt = {1'b0, r_a[WIDTH-1:1]};
            c_sra:   w_shift_nxt = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
            default: w_shift_nxt = r_a;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_res_nxt   = '0;
        w_carry_nxt = 1'b0;
        w_ovf_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_state_nxt = SHIFT;
                    end
`ifdef ALU_SEQ_MUL_EN
                    else if (bus.mode == c_mul) begin
                        w_state_nxt = MUL;
                    end
`endif
                    else begin
                        // Single-cycle ops, zero-length shifts and reserved modes
                        w_state_nxt = DONE;
                        w_load      = 1'b1;
                        w_res_nxt   = w_is_shift ? bus.a : w_alu_res;
                        w_carry_nxt = w_is_addsub & w_sum_full[WIDTH];
                        w_ovf_nxt   = w_is_addsub & w_add_ovf;
                    end
                end
            end
            SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_state_nxt = DONE;
                    w_load      = 1'b1;
                    w_res_nxt   = w_shift_nxt;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                if (r_mcnt == c_cw'(1)) begin
                    w_state_nxt = DONE;
                    w_load      = 1'b1;
                    w_res_nxt   = w_acc_nxt[WIDTH-1:0];
                    w_ovf_nxt   = |w_acc_nxt[2*WIDTH-1:WIDTH];
                end
            end
`endif
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_mode   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_mcnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a    <= bus.a;
                        r_mode <= bus.mode;
                        r_cnt  <= w_shamt;
`ifdef ALU_SEQ_MUL_EN
                        r_acc   <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, bus.a};
                        r_mplr  <= bus.b;
                        r_mcnt  <= c_cw'(WIDTH);
`endif
                    end
                end
                SHIFT: begin
                    r_a   <= w_shift_nxt;
                    r_cnt <= r_cnt - SHW'(1);
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    r_acc   <= w_acc_nxt;
                    r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_mplr  <= {1'b0, r_mplr[WIDTH-1:1]};
                    r_mcnt  <= r_mcnt - c_cw'(1);
                end
`endif
                default: ;
            endcase
            if (w_load) begin
                r_result <= w_res_nxt;
                r_zero   <= ~|w_res_nxt;
                r_carry  <= w_carry_nxt;
                r_ovf    <= w_ovf_nxt;
            end
        end
    end

    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;
    assign bus.zero   = r_zero;
    assign bus.carry  = r_carry;
    assign bus.ovf    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// tb_alu_seq : randomized + directed stimulus; expected responses are queued
// at issue time and compared by an independent monitor whenever done fires.
`default_nettype none

module tb_alu_seq;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         o;
        int           at;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the operation definitions
    function automatic exp_t model(input logic [3:0] m, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input int now);
        exp_t e;
        int   sh;
        int   lat;
        int   r;
        e.res = '0; e.c = 1'b0; e.o = 1'b0; lat = 1;
        sh = int'(y[3:0]);
        case (m)
            4'd0: begin
                e.res = x + y;
                e.c   = (int'(x) + int'(y)) > 65535;
                r     = int'($signed(x)) + int'($signed(y));
                e.o   = (r > 32767) || (r < -32768);
            end
            4'd1: begin
                e.res = x - y;
                e.c   = (x >= y);
                r     = int'($signed(x)) - int'($signed(y));
                e.o   = (r > 32767) || (r < -32768);
            end
            4'd2: e.res = x & y;
            4'd3: e.res = x | y;
            4'd4: e.res = x ^ y;
            4'd5: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            4'd6: begin e.res = x << sh; lat = (sh == 0) ? 1 : sh + 1; end
            4'd7: begin e.res = x >> sh; lat = (sh == 0) ? 1 : sh + 1; end
            4'd8: begin e.res = $signed(x) >>> sh; lat = (sh == 0) ? 1 : sh + 1; end
`ifdef ALU_SEQ_MUL_EN
            4'd9: begin
                logic [2*W-1:0] p;
                p     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.res = p[W-1:0];
                e.o   = (p[2*W-1:W] != 0);
                lat   = W + 1;
            end
`endif
            default: ;
        endcase
        e.z  = (e.res == 0);
        e.at = now + lat;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.done) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: got done=1, expected none (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("result", bus.result, e.res);
                check("zero", bus.zero, e.z);
                check("carry", bus.carry, e.c);
                check("ovf", bus.ovf, e.o);
                check("done_cycle", cyc, e.at);
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while ((bus.busy || bus.done) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_wait: got busy=%0b, expected 0 within 100 cycles", bus.busy);
        end
    endtask

    // Called at a negedge; poke>0 pulses an extra start that should be ignored
    task automatic issue(input logic [3:0] m, input logic [W-1:0] x, input logic [W-1:0] y, input int poke);
        wait_idle();
        bus.start = 1'b1; bus.mode = m; bus.a = x; bus.b = y;
        q.push_back(model(m, x, y, cyc));
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = 4'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        if (poke > 0) begin
            repeat (poke - 1) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] corner [4];
        logic [3:0]   m;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           guard;
        corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;
        bus.start = 1'b0; bus.mode = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_zero", bus.zero, 1);
        check("rst_carry", bus.carry, 0);
        check("rst_ovf", bus.ovf, 0);

        issue(4'd0, 16'hFFFF, 16'h0001, 0);
        issue(4'd5, 16'h8000, 16'h0001, 0);
        issue(4'd5, 16'h7FFF, 16'hFFFF, 0);
        issue(4'd8, 16'h8010, 16'h0004, 2);
        issue(4'd9, 16'h0100, 16'h0100, 0);
        issue(4'd9, 16'h0003, 16'h0005, 0);
        issue(4'd6, 16'h1234, 16'h0000, 0);
        issue(4'd13, 16'h1234, 16'h5678, 0);
        issue(4'd1, 16'h0000, 16'h8000, 0);
        issue(4'd1, 16'h0005, 16'h0007, 0);

        // start during the DONE cycle must not launch another operation
        issue(4'd2, 16'hF0F0, 16'h0FF0, 0);
        bus.start = 1'b1; bus.mode = 4'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("done_start_busy", bus.busy, 0);
        check("done_start_done", bus.done, 0);

        // reset wins over a simultaneous start
        wait_idle();
        reset = 1'b1; bus.start = 1'b1; bus.mode = 4'd0; bus.a = 16'h0001; bus.b = 16'h0001;
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        check("rst_start_busy", bus.busy, 0);
        check("rst_start_result", bus.result, 0);
        check("rst_start_zero", bus.zero, 1);

        // reset in the third cycle of a long SLL aborts it silently
        issue(4'd3, 16'h00A5, 16'h5A00, 0);
        wait_idle();
        bus.start = 1'b1; bus.mode = 4'd6; bus.a = 16'h0001; bus.b = 16'h000F;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_result", bus.result, 0);
        issue(4'd0, 16'h0003, 16'h0004, 0);

        for (int i = 0; i < 200; i++) begin
            m = 4'($urandom_range(0, 15));
            x = W'($urandom);
            y = W'($urandom);
            if ($urandom_range(0, 3) == 0) x = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) y = corner[$urandom_range(0, 3)];
            issue(m, x, y, ((m >= 4'd6) && (m <= 4'd8) && (y[3:0] >= 4'd2)) ? 2 : 0);
        end

        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits, legal values 8 to 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH): width of the shift-amount field taken from b[SHW-1:0].
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 The block SHALL have port mode, input, 4 bits: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL, 8 SRA, 9 MUL; 10-15 reserved.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in SHIFT, MUL or DONE.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse, high exactly when result and flags become valid.
REQ-010 The block SHALL have port result, output, WIDTH bits: registered result, held until the next done.
REQ-011 The block SHALL have ports zero, carry and ovf, output, 1 bit each: registered flags, updated only with done.

Function
REQ-012 The block SHALL use FSM states IDLE, SHIFT, MUL and DONE; reset forces IDLE.
REQ-013 On start in IDLE, the block SHALL capture a, b and mode into internal registers; later input changes SHALL NOT affect the operation in progress.
REQ-014 Modes 0-5 and reserved modes SHALL go IDLE->DONE; done SHALL be asserted the cycle after the start cycle (latency 1).
REQ-015 ADD/SUB SHALL use one shared adder computing a + (b or ~b) + cin, with cin=1 for SUB and SLT.
REQ-016 carry SHALL be the adder carry-out for ADD and SUB (SUB: carry=1 means no borrow); ovf SHALL be signed overflow for ADD/SUB; both SHALL be 0 for all other modes.
REQ-017 SLT SHALL produce result = {0..., sign(a-b) XOR ovf(a-b)}, a correct signed compare that includes the overflow case.
REQ-018 Reserved modes SHALL produce result 0, zero=1 and carry=ovf=0.
REQ-019 Shift modes (SLL, SRL, SRA) SHALL shift one bit per cycle in SHIFT, using a count loaded from b[SHW-1:0].
REQ-020 Shift latency SHALL be shamt+1 cycles; shamt=0 SHALL go directly to DONE, giving latency 1 with result=a.
REQ-021 SRA SHALL replicate a[WIDTH-1]; SRL and SLL SHALL fill with 0.
REQ-022 MUL SHALL be a shift-add unsigned multiply, one multiplier bit per cycle, for exactly WIDTH cycles in MUL.
REQ-023 MUL result SHALL be product[WIDTH-1:0], giving latency WIDTH+1 cycles.
REQ-024 MUL ovf SHALL be 1 iff product[2*WIDTH-1:WIDTH] is nonzero; MUL carry SHALL be 0.
REQ-025 DONE SHALL last one cycle, pulse done, then return to IDLE; a start in the DONE cycle SHALL be ignored.
REQ-026 A start while busy=1 SHALL be ignored with no error indication; a new start is accepted only in IDLE, so back-to-back issue is one operation per 2 cycles minimum.
REQ-027 zero SHALL be the NOR-reduction of the final result, registered with done.

Reset
REQ-028 With reset high at a clock edge, the block SHALL set state=IDLE, busy=0, done=0, result=0, zero=1, carry=0 and ovf=0, and clear all internal operand, counter and accumulator registers.
REQ-029 Reset SHALL override start in the same cycle.
REQ-030 Reset asserted mid-operation (SHIFT or MUL) SHALL abort the operation with no done pulse.

Configuration
REQ-031 The macro ALU_SEQ_MUL_EN SHALL control the multiplier.
REQ-032 With ALU_SEQ_MUL_EN defined, the MUL state, accumulator and multiplier counter SHALL exist and mode 9 SHALL behave per REQ-022 to REQ-024.
REQ-033 Without ALU_SEQ_MUL_EN, no multiplier logic SHALL be synthesised and mode 9 SHALL be treated as reserved per REQ-018, with latency 1.

Verification
REQ-034 ADD wrap, WIDTH=16: start, mode=0, a=16'hFFFF, b=16'h0001 -> done one cycle later; result=0, zero=1, carry=1, ovf=0.
REQ-035 SLT overflow: mode=5, a=16'h8000, b=16'h0001 -> result=1; and a=16'h7FFF, b=16'hFFFF -> result=0.
REQ-036 SRA timing: mode=8, a=16'h8010, b=4 -> done exactly 5 cycles after start; result=16'hF801; an extra start pulsed mid-shift is ignored.
REQ-037 MUL, with ALU_SEQ_MUL_EN: mode=9, a=16'h0100, b=16'h0100 -> done after 17 cycles; result=0, zero=1, ovf=1.
REQ-038 MUL, without ALU_SEQ_MUL_EN: mode=9 -> done after 1 cycle; result=0, zero=1.
REQ-039 Reset abort: reset pulsed in cycle 3 of a SLL with shamt=15 -> no done pulse; busy=0 and result=0 the cycle after reset; a new ADD then completes normally.
